// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: field widths, class-flag bit positions, special
// encodings, exception bit positions and the operand/result classifier.
package bf16_pkg;

   localparam int NUM_WIDTH  = 16;
   localparam int EXP_WIDTH  = 8;
   localparam int SIG_WIDTH  = 7;
   localparam int FLAG_WIDTH = 4;
   localparam int BIAS       = 127;

   // One-hot class flag bit positions, {nan,zero,inf,norm}
   localparam int FLAG_NAN  = 3;
   localparam int FLAG_ZERO = 2;
   localparam int FLAG_INF  = 1;
   localparam int FLAG_NORM = 0;

   // Sticky exception bit positions, {invalid,overflow,underflow,inexact}
   localparam int EXC_INVALID   = 3;
   localparam int EXC_OVERFLOW  = 2;
   localparam int EXC_UNDERFLOW = 1;
   localparam int EXC_INEXACT   = 0;

   localparam logic [NUM_WIDTH-1:0] QNAN    = 16'h7FFF;
   localparam logic [NUM_WIDTH-2:0] INF_MAG = 15'h7F80;

   typedef logic [FLAG_WIDTH-1:0] flag_t;

   // Classify by exponent/fraction. Only an all-ones fraction counts as NaN;
   // any other all-ones exponent is infinity. A zero exponent is zero, which
   // also flushes subnormal operands.
   function automatic flag_t bf16_classify(input logic [EXP_WIDTH-1:0] e,
                                           input logic [SIG_WIDTH-1:0] f);
      flag_t fl;
      fl = '0;
      if (e == '1) begin
         if (f == '1) fl[FLAG_NAN] = 1'b1;
         else         fl[FLAG_INF] = 1'b1;
      end else if (e == '0) begin
         fl[FLAG_ZERO] = 1'b1;
      end else begin
         fl[FLAG_NORM] = 1'b1;
      end
      return fl;
   endfunction

endpackage

// File: rtl/bf16_mul_pipe_if.sv
// Operand/result stream bundle for bf16_mul_pipe. Names are from the
// multiplier's point of view (i_* flow into it, o_* flow out of it).
// valid/ready: a beat moves on a rising edge where valid and ready are both
// high; while valid is high and ready is low the sender holds its payload.
interface bf16_mul_pipe_if;
   import bf16_pkg::*;

   logic                 i_valid;
   logic                 o_ready;
   logic [NUM_WIDTH-1:0] i_a;
   logic [NUM_WIDTH-1:0] i_b;
   logic                 o_valid;
   logic                 i_ready;
   logic [NUM_WIDTH-1:0] o_data;
   flag_t                o_flag;

   modport slave (
      input  i_valid, i_a, i_b, i_ready,
      output o_ready, o_valid, o_data, o_flag
   );

   modport master (
      output i_valid, i_a, i_b, i_ready,
      input  o_ready, o_valid, o_data, o_flag
   );

endinterface

// File: rtl/bf16_mul_round.sv
// Final-stage normalise and round-to-nearest-even for the BF16 product.
// Takes the raw 16-bit significand product (value in [1,4)) and the biased
// exponent sum; returns the packed BF16 result with inf on overflow and a
// signed zero on underflow (no subnormal results).
module bf16_mul_round
   import bf16_pkg::*;
(
   input  logic                 i_sign,
   input  logic signed [9:0]    i_exp,
   input  logic [15:0]          i_prod,
   output logic [NUM_WIDTH-1:0] o_res,
   output logic                 o_ovf,
   output logic                 o_unf,
   output logic                 o_inexact
);

   logic [SIG_WIDTH-1:0] frac;
   logic                 guard;
   logic                 sticky;
   logic                 round_up;
   logic [SIG_WIDTH:0]   frac_sum;
   logic signed [9:0]    e_norm;
   logic signed [9:0]    e_rnd;

   // Normalise, round to nearest even, then range-check the exponent
   always_comb begin
      if (i_prod[15]) begin
         frac   = i_prod[14:8];
         guard  = i_prod[7];
         sticky = |i_prod[6:0];
         e_norm = i_exp + 10'sd1;
      end else begin
         frac   = i_prod[13:7];
         guard  = i_prod[6];
         sticky = |i_prod[5:0];
         e_norm = i_exp;
      end
      round_up = guard & (sticky | frac[0]);
      frac_sum = {1'b0, frac} + {{SIG_WIDTH{1'b0}}, round_up};
      // A carry out of the fraction leaves it at zero and bumps the exponent
      e_rnd    = frac_sum[SIG_WIDTH] ? (e_norm + 10'sd1) : e_norm;
      o_ovf    = (e_rnd >= 10'sd255);
      o_unf    = (e_rnd <= 10'sd0);
      o_inexact = guard | sticky | o_ovf | o_unf;
      if (o_ovf) begin
         o_res = {i_sign, INF_MAG};
      end else if (o_unf) begin
         o_res = {i_sign, {(NUM_WIDTH-1){1'b0}}};
      end else begin
         o_res = {i_sign, e_rnd[7:0], frac_sum[SIG_WIDTH-1:0]};
      end
   end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Three-stage BF16 multiplier: S1 unpack/classify/special select,
// S2 8x8 significand product, S3 normalise/round into the output register.
// The whole pipe shifts together whenever the output is empty or being taken.
// Optional sticky exception flags when BF16_MUL_EXC_EN is defined.
module bf16_mul_pipe
   import bf16_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
`ifdef BF16_MUL_EXC_EN
   input  logic       i_exc_clr,
   output logic [3:0] o_exc,
`endif
   bf16_mul_pipe_if.slave bus
);

   logic advance;

   flag_t cls_a;
   flag_t cls_b;
   logic  sel_nan;
   logic  sel_inf;
   logic  sel_zero;

   logic                 s1_valid_d, s1_valid_q;
   logic                 s1_sign_d, s1_sign_q;
   logic signed [9:0]    s1_exp_d, s1_exp_q;
   logic [7:0]           s1_sig_a_d, s1_sig_a_q;
   logic [7:0]           s1_sig_b_d, s1_sig_b_q;
   logic                 s1_special_d, s1_special_q;
   logic [NUM_WIDTH-1:0] s1_spec_val_d, s1_spec_val_q;

   logic                 s2_valid_d, s2_valid_q;
   logic                 s2_sign_d, s2_sign_q;
   logic signed [9:0]    s2_exp_d, s2_exp_q;
   logic [15:0]          s2_prod_d, s2_prod_q;
   logic                 s2_special_d, s2_special_q;
   logic [NUM_WIDTH-1:0] s2_spec_val_d, s2_spec_val_q;

   logic                 out_valid_d, out_valid_q;
   logic [NUM_WIDTH-1:0] out_data_d, out_data_q;
   flag_t                out_flag_d, out_flag_q;

   logic [NUM_WIDTH-1:0] rnd_res;
   logic                 rnd_ovf;
   logic                 rnd_unf;
   logic                 rnd_inexact;

   assign advance     = ~out_valid_q | bus.i_ready;
   assign bus.o_ready = advance;
   assign bus.o_valid = out_valid_q;
   assign bus.o_data  = out_data_q;
   assign bus.o_flag  = out_flag_q;

   // Classify both operands and decide which special result, if any, wins
   always_comb begin
      cls_a    = bf16_classify(bus.i_a[14:7], bus.i_a[6:0]);
      cls_b    = bf16_classify(bus.i_b[14:7], bus.i_b[6:0]);
      sel_nan  = cls_a[FLAG_NAN] | cls_b[FLAG_NAN]
               | (cls_a[FLAG_INF] & cls_b[FLAG_ZERO])
               | (cls_a[FLAG_ZERO] & cls_b[FLAG_INF]);
      sel_inf  = cls_a[FLAG_INF] | cls_b[FLAG_INF];
      sel_zero = cls_a[FLAG_ZERO] | cls_b[FLAG_ZERO];
   end

   bf16_mul_round u_round (
      .i_sign    (s2_sign_q),
      .i_exp     (s2_exp_q),
      .i_prod    (s2_prod_q),
      .o_res     (rnd_res),
      .o_ovf     (rnd_ovf),
      .o_unf     (rnd_unf),
      .o_inexact (rnd_inexact)
   );

   // Next-state for all three stages; everything holds unless the pipe advances
   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_sign_d     = s1_sign_q;
      s1_exp_d      = s1_exp_q;
      s1_sig_a_d    = s1_sig_a_q;
      s1_sig_b_d    = s1_sig_b_q;
      s1_special_d  = s1_special_q;
      s1_spec_val_d = s1_spec_val_q;
      s2_valid_d    = s2_valid_q;
      s2_sign_d     = s2_sign_q;
      s2_exp_d      = s2_exp_q;
      s2_prod_d     = s2_prod_q;
      s2_special_d  = s2_special_q;
      s2_spec_val_d = s2_spec_val_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_flag_d    = out_flag_q;
      if (advance) begin
         // S1: unpack and special select (NaN ignores sign)
         s1_valid_d   = bus.i_valid;
         s1_sign_d    = bus.i_a[15] ^ bus.i_b[15];
         s1_exp_d     = $signed({2'b00, bus.i_a[14:7]}) + $signed({2'b00, bus.i_b[14:7]})
                      - 10'(BIAS);
         s1_sig_a_d   = {1'b1, bus.i_a[6:0]};
         s1_sig_b_d   = {1'b1, bus.i_b[6:0]};
         s1_special_d = sel_nan | sel_inf | sel_zero;
         if (sel_nan)      s1_spec_val_d = QNAN;
         else if (sel_inf) s1_spec_val_d = {s1_sign_d, INF_MAG};
         else              s1_spec_val_d = {s1_sign_d, {(NUM_WIDTH-1){1'b0}}};
         // S2: significand product
         s2_valid_d    = s1_valid_q;
         s2_sign_d     = s1_sign_q;
         s2_exp_d      = s1_exp_q;
         s2_prod_d     = {8'b0, s1_sig_a_q} * {8'b0, s1_sig_b_q};
         s2_special_d  = s1_special_q;
         s2_spec_val_d = s1_spec_val_q;
         // S3: rounded or special result, class flag registered alongside
         out_valid_d = s2_valid_q;
         out_data_d  = s2_special_q ? s2_spec_val_q : rnd_res;
         out_flag_d  = bf16_classify(out_data_d[14:7], out_data_d[6:0]);
      end
   end

   // Pipeline registers; reset drops every in-flight item
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_exp_q      <= '0;
         s1_sig_a_q    <= '0;
         s1_sig_b_q    <= '0;
         s1_special_q  <= 1'b0;
         s1_spec_val_q <= '0;
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_exp_q      <= '0;
         s2_prod_q     <= '0;
         s2_special_q  <= 1'b0;
         s2_spec_val_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_flag_q    <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_exp_q      <= s1_exp_d;
         s1_sig_a_q    <= s1_sig_a_d;
         s1_sig_b_q    <= s1_sig_b_d;
         s1_special_q  <= s1_special_d;
         s1_spec_val_q <= s1_spec_val_d;
         s2_valid_q    <= s2_valid_d;
         s2_sign_q     <= s2_sign_d;
         s2_exp_q      <= s2_exp_d;
         s2_prod_q     <= s2_prod_d;
         s2_special_q  <= s2_special_d;
         s2_spec_val_q <= s2_spec_val_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_flag_q    <= out_flag_d;
      end
   end

`ifdef BF16_MUL_EXC_EN
   logic [3:0] out_exc_d, out_exc_q;
   logic [3:0] o_exc_d, o_exc_q;

   assign o_exc = o_exc_q;

   // Per-result exception bits travel with the result; the sticky copy
   // accumulates only on an output transfer and a clear beats a same-cycle set
   always_comb begin
      out_exc_d = out_exc_q;
      if (advance) begin
         out_exc_d = '0;
         if (s2_valid_q) begin
            if (s2_special_q) begin
               out_exc_d[EXC_INVALID] = (s2_spec_val_q == QNAN);
            end else begin
               out_exc_d[EXC_OVERFLOW]  = rnd_ovf;
               out_exc_d[EXC_UNDERFLOW] = rnd_unf;
               out_exc_d[EXC_INEXACT]   = rnd_inexact;
            end
         end
      end
      o_exc_d = o_exc_q;
      if (out_valid_q && bus.i_ready) o_exc_d = o_exc_q | out_exc_q;
      if (i_exc_clr) o_exc_d = '0;
   end

   // Exception registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_exc_q <= '0;
         o_exc_q   <= '0;
      end else begin
         out_exc_q <= out_exc_d;
         o_exc_q   <= o_exc_d;
      end
   end
`else
   logic unused_exc;
   assign unused_exc = rnd_ovf ^ rnd_unf ^ rnd_inexact;
`endif

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Bench for bf16_mul_pipe: directed operand table driven with steady,
// gapped, random and forced backpressure; results checked in order against
// an expected queue. Exception flags checked when BF16_MUL_EXC_EN is defined.
module tb_bf16_mul_pipe;
   import bf16_pkg::*;

   localparam int NT = 24;

   logic i_clk = 1'b0;
   logic i_rst_n;
`ifdef BF16_MUL_EXC_EN
   logic       i_exc_clr;
   logic [3:0] o_exc;
`endif

   bf16_mul_pipe_if bus ();

   bf16_mul_pipe dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
`ifdef BF16_MUL_EXC_EN
      .i_exc_clr (i_exc_clr),
      .o_exc     (o_exc),
`endif
      .bus       (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // ---------------- stimulus table ----------------
   logic [15:0] tab_a [NT] = '{
      16'h3F80, 16'h4000, 16'hC000, 16'h3FC0, 16'h3F81, 16'h7F80, 16'h7F00, 16'h0080,
      16'h4040, 16'h3F00, 16'h7FFF, 16'h0001, 16'h8000, 16'hFF80, 16'hBF80, 16'h2000,
      16'h1F80, 16'h4000, 16'h7F7F, 16'h3FC0, 16'h3FFE, 16'h0000, 16'h7FC0, 16'hBF80};
   logic [15:0] tab_b [NT] = '{
      16'h3F80, 16'h4040, 16'h4040, 16'h3F81, 16'h3F81, 16'h0000, 16'h7F00, 16'h0080,
      16'h4040, 16'h4000, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'hFF80, 16'h2000,
      16'h2000, 16'h7F00, 16'h3F80, 16'h3FC0, 16'h3F81, 16'hFF80, 16'h3F80, 16'h0000};
   logic [15:0] tab_p [NT] = '{
      16'h3F80, 16'h40C0, 16'hC0C0, 16'h3FC2, 16'h3F82, 16'h7FFF, 16'h7F80, 16'h0000,
      16'h4110, 16'h3F80, 16'h7FFF, 16'h0000, 16'h8000, 16'hFF80, 16'h7F80, 16'h0080,
      16'h0000, 16'h7F80, 16'h7F7F, 16'h4010, 16'h4000, 16'h7FFF, 16'h7F80, 16'h8000};
   logic [3:0] tab_f [NT] = '{
      4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0010, 4'b0100,
      4'b0001, 4'b0001, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001,
      4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0010, 4'b0100};

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];
   logic [19:0] mon_e;
   int total = 0;
   int bad = 0;
   int sent = 0;
   int recv = 0;
   int acc_cyc = 0;
   int ready_mode = 0;  // 0: ready high, 1: random, 2: held low

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: pop on transfer, check hold behaviour while stalled
   always @(negedge i_clk) begin
      if (i_rst_n && bus.o_valid) begin
         if (bus.i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", {12'b0, bus.o_data, bus.o_flag}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_data", {16'b0, bus.o_data}, {16'b0, mon_e[19:4]});
               check("out_flag", {28'b0, bus.o_flag}, {28'b0, mon_e[3:0]});
               recv++;
            end
         end else begin
            check("stall_ready", {31'b0, bus.o_ready}, 32'd0);
            if (exp_q.size() != 0)
               check("stall_hold", {12'b0, bus.o_data, bus.o_flag}, {12'b0, exp_q[0]});
         end
      end
   end

   // Sole driver of i_ready
   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         case (ready_mode)
            1:       bus.i_ready = 1'($urandom_range(0, 1));
            2:       bus.i_ready = 1'b0;
            default: bus.i_ready = 1'b1;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [19:0] e);
      int n;
      n = 0;
      bus.i_valid = 1'b1;
      bus.i_a     = a;
      bus.i_b     = b;
      exp_q.push_back(e);
      sent++;
      @(negedge i_clk);
      while (!bus.o_ready && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      check("send_accept", {31'b0, bus.o_ready}, 32'd1);
      acc_cyc = cyc;
      @(posedge i_clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      @(posedge i_clk);
      #1;
   endtask

`ifdef BF16_MUL_EXC_EN
   task automatic exc_case(input int idx, input logic [3:0] exp_exc);
      i_exc_clr = 1'b1;
      idle(1);
      i_exc_clr = 1'b0;
      check("exc_clr", {28'b0, o_exc}, 32'd0);
      send(tab_a[idx], tab_b[idx], {tab_p[idx], tab_f[idx]});
      drain();
      check("exc_sticky", {28'b0, o_exc}, {28'b0, exp_exc});
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      int n;
      i_rst_n     = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
`ifdef BF16_MUL_EXC_EN
      i_exc_clr   = 1'b0;
`endif
      idle(3);
      check("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
      check("rst_o_data", {16'b0, bus.o_data}, 32'd0);
      check("rst_o_flag", {28'b0, bus.o_flag}, 32'd0);
      check("rst_o_ready", {31'b0, bus.o_ready}, 32'd1);
`ifdef BF16_MUL_EXC_EN
      check("rst_o_exc", {28'b0, o_exc}, 32'd0);
`endif
      i_rst_n = 1'b1;
      idle(1);

      // Latency of a lone 1.0 x 1.0
      send(16'h3F80, 16'h3F80, {16'h3F80, 4'b0001});
      n = 0;
      while (!bus.o_valid && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      check("latency", cyc - acc_cyc, 32'd3);
      drain();

      // Whole table, ready high, random gaps
      for (int i = 0; i < NT; i++) begin
         send(tab_a[i], tab_b[i], {tab_p[i], tab_f[i]});
         idle($urandom_range(0, 2));
      end
      drain();

      // Whole table back to back under random backpressure
      ready_mode = 1;
      for (int i = NT - 1; i >= 0; i--)
         send(tab_a[i], tab_b[i], {tab_p[i], tab_f[i]});
      drain();
      ready_mode = 0;
      idle(2);

      // Five back-to-back inputs, ready held low for six cycles from cycle 4
      fork
         begin
            for (int i = 1; i <= 5; i++)
               send(tab_a[i], tab_b[i], {tab_p[i], tab_f[i]});
         end
         begin
            repeat (3) @(posedge i_clk);
            ready_mode = 2;
            repeat (6) @(posedge i_clk);
            ready_mode = 0;
         end
      join
      drain();
      check("count_after_bp", recv, sent);

`ifdef BF16_MUL_EXC_EN
      exc_case(5, 4'b1000);
      exc_case(6, 4'b0101);
      exc_case(7, 4'b0011);
      exc_case(0, 4'b0000);
      i_exc_clr = 1'b1;
      idle(1);
      i_exc_clr = 1'b0;
`endif

      // Reset with two items in flight
      send(tab_a[1], tab_b[1], {tab_p[1], tab_f[1]});
      send(tab_a[2], tab_b[2], {tab_p[2], tab_f[2]});
      i_rst_n = 1'b0;
      idle(1);
      check("rst_flight_valid", {31'b0, bus.o_valid}, 32'd0);
      exp_q.delete();
      sent = sent - 2;
      idle(1);
      i_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("rst_pipe_empty", {31'b0, bus.o_valid}, 32'd0);
      end
      check("final_count", recv, sent);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #400000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
